// File: rtl/exp_reader_pkg.sv
// Shared definitions for the exponential accelerator result reader.
// Holds the reader FSM encoding, the Q2.16 format shared with the
// accelerator, and the BCD nibble width.
package exp_reader_pkg;
  localparam int INT_W  = 2;
  localparam int FRAC_W = 16;
  localparam int BCD_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    CAPTURE,
    CONV
  } state_t;
endpackage

// File: rtl/frac_mul10.sv
// One step of binary-fraction to decimal conversion.
// Multiplies an unsigned fraction by ten. The carry into the integer
// nibble is the next decimal digit, and the low bits are the remainder.
//   f      : unsigned fraction, FRAC_W bits
//   digit  : next decimal digit, 0..9
//   f_next : fraction left over for the following digit
module frac_mul10 #(
  parameter int FRAC_W = exp_reader_pkg::FRAC_W
) (
  input  logic [FRAC_W-1:0] f,
  output logic [3:0]        digit,
  output logic [FRAC_W-1:0] f_next
);
  logic [FRAC_W+3:0] fx, p;

  // 10*f = 8*f + 2*f. Because f < 1, p < 10, so the top nibble is a decimal digit.
  assign fx     = {4'b0, f};
  assign p      = (fx << 3) + (fx << 1);
  assign digit  = p[FRAC_W+3:FRAC_W];
  assign f_next = p[FRAC_W-1:0];
endmodule

// File: rtl/exp_result_reader.sv
// Pops one Q2.16 result from the accelerator FIFO for each "next" request.
// It then converts the result serially into BCD: one integer digit plus
// FRAC_DIGITS truncated fraction digits, one fraction digit per cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   next       : one-cycle fetch request
//   usedw      : FIFO fill level, 0 = empty
//   q          : FIFO read data, valid the cycle after read
//   read       : FIFO pop strobe
//   busy       : fetch/conversion in progress
//   valid      : int_bcd/frac_bcd hold a completed conversion
//   empty_err  : pulse when next arrives with the FIFO empty
//   int_bcd    : integer digit
//   frac_bcd   : fraction digits, most significant digit in the top nibble
module exp_result_reader #(
  parameter int INT_W       = exp_reader_pkg::INT_W,
  parameter int FRAC_W      = exp_reader_pkg::FRAC_W,
  parameter int DATA_W      = INT_W + FRAC_W,
  parameter int USEDW_W     = 3,
  parameter int FRAC_DIGITS = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        next,
  input  logic [USEDW_W-1:0]                          usedw,
  input  logic [DATA_W-1:0]                           q,
  output logic                                        read,
  output logic                                        busy,
  output logic                                        valid,
  output logic                                        empty_err,
  output logic [exp_reader_pkg::BCD_W-1:0]            int_bcd,
  output logic [exp_reader_pkg::BCD_W*FRAC_DIGITS-1:0] frac_bcd
);
  import exp_reader_pkg::*;

  localparam int CNT_W = (FRAC_DIGITS > 1) ? $clog2(FRAC_DIGITS) : 1;

  state_t            state, state_nx;
  logic [FRAC_W-1:0] f, f_next;
  logic [3:0]        digit;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic              have_word;

  assign last      = (cnt == CNT_W'(FRAC_DIGITS - 1));
  assign have_word = (usedw != '0);

  frac_mul10 #(.FRAC_W(FRAC_W)) u_mul10 (
    .f      (f),
    .digit  (digit),
    .f_next (f_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // read and busy are decoded from the state alone.
  // POP is the only state that pops the FIFO.
  always_comb begin
    state_nx = state;
    read     = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:    if (next && have_word) state_nx = POP;
      POP:     begin read = 1'b1; busy = 1'b1; state_nx = CAPTURE; end
      CAPTURE: begin busy = 1'b1; state_nx = CONV; end
      CONV:    begin busy = 1'b1; if (last) state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      empty_err <= 1'b0;
      int_bcd   <= '0;
      frac_bcd  <= '0;
      f         <= '0;
      cnt       <= '0;
    end else begin
      empty_err <= 1'b0;
      case (state)
        // A request on an empty FIFO leaves the previous result on display.
        IDLE: if (next) begin
          if (have_word) valid     <= 1'b0;
          else           empty_err <= 1'b1;
        end
        CAPTURE: begin
          int_bcd  <= {{(BCD_W-INT_W){1'b0}}, q[DATA_W-1:FRAC_W]};
          f        <= q[FRAC_W-1:0];
          frac_bcd <= '0;
          cnt      <= '0;
        end
        CONV: begin
          f   <= f_next;
          cnt <= cnt + 1'b1;
          // The first digit goes to the top nibble and later digits fill downward.
          for (int i = 0; i < FRAC_DIGITS; i++)
            if (cnt == CNT_W'(FRAC_DIGITS - 1 - i))
              frac_bcd[i*BCD_W +: BCD_W] <= digit;
          if (last) valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exp_result_reader.sv
module tb_exp_result_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        next;
  logic [2:0]  usedw;
  logic [17:0] q = '0;
  logic        read, busy, valid, empty_err;
  logic [3:0]  int_bcd;
  logic [15:0] frac_bcd;

  int n_cmp = 0;
  int n_err = 0;

  exp_result_reader dut (
    .clk       (clk),
    .rst       (rst),
    .next      (next),
    .usedw     (usedw),
    .q         (q),
    .read      (read),
    .busy      (busy),
    .valid     (valid),
    .empty_err (empty_err),
    .int_bcd   (int_bcd),
    .frac_bcd  (frac_bcd)
  );

  always #5 clk = ~clk;

  // FIFO model: the popped word appears on q the cycle after read.
  logic [17:0] mem [0:15];
  int rd_ptr = 0;
  always @(posedge clk) begin
    if (read) begin
      q      <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [17:0] word;
    logic [3:0]  ei;
    logic [15:0] ef;
  } vec_t;

  vec_t vecs [0:6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge. It asserts next and then follows the run for seven
  // cycles. With extra set, next is pulsed again while the run is busy.
  task automatic do_run(input string tag, input logic [3:0] ei, input logic [15:0] ef,
                        input bit extra);
    int rd = 0, bz = 0, vk = 0, rk = 0, ee = 0;
    int ptr0;
    ptr0 = rd_ptr;
    usedw = 3'd3;
    next = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      next = extra && (k == 2 || k == 4);
      if (read) begin rd++; rk = k; end
      if (busy) bz++;
      if (empty_err) ee++;
      if (k == 1) chk({tag, " valid_cleared"}, valid, 0);
      if (valid && vk == 0) vk = k;
    end
    chk({tag, " read_count"}, rd, 1);
    chk({tag, " read_edge1"}, rk, 1);
    chk({tag, " busy_cycles"}, bz, 6);
    chk({tag, " valid_edge6"}, vk, 7);
    chk({tag, " no_empty_err"}, ee, 0);
    chk({tag, " pops"}, rd_ptr - ptr0, 1);
    chk({tag, " int_bcd"}, int_bcd, ei);
    chk({tag, " frac_bcd"}, frac_bcd, ef);
  endtask

  initial begin
    vecs[0] = '{18'h1_8000, 4'd1, 16'h5000};
    vecs[1] = '{18'h0_4000, 4'd0, 16'h2500};
    vecs[2] = '{18'h3_1999, 4'd3, 16'h0999};
    vecs[3] = '{18'h2_FFFF, 4'd2, 16'h9999};
    vecs[4] = '{18'h0_0001, 4'd0, 16'h0000};
    vecs[5] = '{18'h0_C000, 4'd0, 16'h7500};
    vecs[6] = '{18'h1_0000, 4'd1, 16'h0000};
    for (int i = 0; i < 7; i++) mem[i] = vecs[i].word;
    mem[7]  = 18'h0_C000;  // busy-next run
    mem[8]  = 18'h1_4000;  // aborted by reset
    mem[9]  = 18'h0_8000;  // after reset
    for (int i = 10; i < 16; i++) mem[i] = '0;

    rst = 1'b1; next = 1'b0; usedw = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset read", read, 0);
    chk("reset busy", busy, 0);
    chk("reset valid", valid, 0);
    chk("reset empty_err", empty_err, 0);
    chk("reset int_bcd", int_bcd, 0);
    chk("reset frac_bcd", frac_bcd, 0);
    rst = 1'b0;
    @(negedge clk);

    // Runs are back to back, so each new next arrives while valid is high.
    for (int i = 0; i < 7; i++)
      do_run($sformatf("vec%0d", i), vecs[i].ei, vecs[i].ef, 1'b0);

    // A request on an empty FIFO pulses empty_err and keeps the last result.
    begin
      int ptr0;
      ptr0 = rd_ptr;
      usedw = 3'd0;
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      chk("empty empty_err", empty_err, 1);
      chk("empty read", read, 0);
      chk("empty busy", busy, 0);
      @(negedge clk);
      chk("empty pulse_ends", empty_err, 0);
      chk("empty valid_kept", valid, 1);
      chk("empty int_kept", int_bcd, 4'd1);
      chk("empty frac_kept", frac_bcd, 16'h0000);
      chk("empty no_pop", rd_ptr - ptr0, 0);
    end

    // next pulsed again on cycles 2 and 4 of a run is ignored.
    do_run("busy_next", 4'd0, 16'h7500, 1'b1);
    repeat (3) @(negedge clk);
    chk("busy_next no_restart", busy, 0);
    chk("busy_next total_pops", rd_ptr, 8);

    // Assert reset during CONV.
    usedw = 3'd3;
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort in_conv", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort read", read, 0);
    chk("abort busy", busy, 0);
    chk("abort valid", valid, 0);
    chk("abort empty_err", empty_err, 0);
    chk("abort int_bcd", int_bcd, 0);
    chk("abort frac_bcd", frac_bcd, 0);
    @(negedge clk);
    chk("abort stays_idle", busy, 0);
    do_run("after_abort", 4'd0, 16'h5000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exp_result_reader.md
Name: exp_result_reader

Overview:
- Downstream consumer of the exponential accelerator's result FIFO.
- On each user "next" request it pops one Q2.16 result (18 bits, 2 integer + 16 fraction bits).
- It converts the result serially into BCD: one integer digit plus FRAC_DIGITS truncated decimal fraction digits, one fraction digit per cycle.
- The digits feed the hex-display drivers, replacing the coarse single-digit fraction lookup.

Parameters:
- DATA_W, 18, FIFO word width (INT_W + FRAC_W)
- INT_W, 2, integer bits in the FIFO word (MSBs)
- FRAC_W, 16, fraction bits in the FIFO word (LSBs)
- USEDW_W, 3, width of the FIFO fill-level input
- FRAC_DIGITS, 4, number of decimal fraction digits produced

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- next  in  1  one-cycle request to fetch and convert the next result (already debounced/edge-detected)
- usedw  in  USEDW_W  FIFO fill level; 0 = empty
- q  in  DATA_W  FIFO read data, valid the cycle after read
- read  out  1  FIFO pop strobe, exactly one cycle per accepted request
- busy  out  1  high while a fetch/conversion is in progress
- valid  out  1  digits below hold a completed conversion
- empty_err  out  1  one-cycle pulse: next arrived while FIFO empty
- int_bcd  out  4  integer part, zero-extended q[DATA_W-1:FRAC_W]
- frac_bcd  out  4*FRAC_DIGITS  fraction digits, most significant digit in the top nibble

Behaviour:
- Reset: state IDLE; read, busy, valid, empty_err = 0; int_bcd, frac_bcd, internal fraction register and digit counter = 0. Reset mid-conversion aborts with no read and no partial digits kept.
- FSM states IDLE, POP, CAPTURE, CONV. All outputs are registered or Moore-decoded.
- IDLE:
  - next & usedw!=0 -> POP; valid cleared on this edge.
  - next & usedw==0 -> stay IDLE; empty_err=1 for one cycle; valid and digits unchanged.
- POP: read=1 (only state driving read) -> CAPTURE.
- CAPTURE:
  - int_bcd <= {0, q[DATA_W-1:FRAC_W]}
  - fraction register f <= q[FRAC_W-1:0]
  - digit counter <= 0 -> CONV
- CONV, one digit per cycle:
  - p = 10*f computed as (f<<3)+(f<<1), width FRAC_W+4.
  - digit = p[FRAC_W+3:FRAC_W], always 0..9.
  - f <= p[FRAC_W-1:0]; digit written to nibble FRAC_DIGITS-1-counter.
  - After digit FRAC_DIGITS-1: valid<=1 -> IDLE.
- Truncation only, no rounding. frac_bcd nibbles not yet written in the current run read 0.
- busy = 1 in POP, CAPTURE and CONV.
- Latency: valid rises FRAC_DIGITS+2 edges after the edge that samples next (6 with defaults). read is high exactly on edge 1 after that sample.
- next while busy is ignored: no read, no empty_err, conversion unaffected.
- next in the same cycle valid is high (IDLE) starts a new run normally.
- The block never pops when usedw==0. usedw changing during a run is irrelevant.

Decomposition:
- Shared package (exp_reader_pkg) holds:
  - the state enum (IDLE/POP/CAPTURE/CONV)
  - Q-format constants INT_W=2, FRAC_W=16, shared with the accelerator
  - BCD_W=4
- One combinational sub-module, frac_mul10:
  - in: f[FRAC_W-1:0]
  - out: digit[3:0], f_next[FRAC_W-1:0]
  - Reusable for other fixed-point display paths.

Test Plan:
- usedw=3, q=18'h1_8000, pulse next:
  - read high one cycle on edge 1
  - busy high for 6 cycles
  - valid at edge 6
  - int_bcd=1, frac_bcd=16'h5000
- q=18'h0_4000 -> int_bcd=0, frac_bcd=16'h2500.
- Boundary values:
  - q=18'h3_1999 -> int_bcd=3, frac_bcd=16'h0999 (truncation).
  - q=18'h2_FFFF -> int_bcd=2, frac_bcd=16'h9999.
  - q=18'h0_0001 -> int_bcd=0, frac_bcd=16'h0000.
- usedw=0, pulse next:
  - empty_err one-cycle pulse
  - read never asserted
  - prior valid/digits unchanged
- next pulsed again on cycles 2 and 4 of a run -> exactly one read; result of the first run unaffected.
- rst asserted during CONV:
  - next cycle all outputs 0, state IDLE
  - a subsequent next converts the next FIFO word correctly
